// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the multi-mode SPI master.
// Optional build macro SPI_LSB_FIRST_EN is consumed by spi_master_mc.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int unsigned cs_width(input int unsigned num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

  // Edge counter must hold 0 .. 2*DATA_W-1.
  function automatic int unsigned edge_width(input int unsigned data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing engine: half-period counter plus edge counter, running only while enabled.
// Emits one-cycle leading/trailing edge strobes and the index of the current edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV_W = 8,
  localparam int unsigned EDGE_W   = edge_width(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [CLK_DIV_W-1:0] i_clk_div,
  output logic                 o_lead_stb,
  output logic                 o_trail_stb,
  output logic [EDGE_W-1:0]    o_edge_cnt
);

  logic [CLK_DIV_W-1:0] r_cnt;
  logic [EDGE_W-1:0]    r_edge;
  logic                 w_tick;

  assign w_tick = i_en && (r_cnt == i_clk_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_edge <= r_edge + EDGE_W'(1);
    end else begin
      r_cnt  <= r_cnt + CLK_DIV_W'(1);
    end
  end

  // Even-numbered edges leave the idle level, odd-numbered edges return to it.
  assign o_lead_stb  = w_tick & ~r_edge[0];
  assign o_trail_stb = w_tick & r_edge[0];
  assign o_edge_cnt  = r_edge;

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-transfer CPOL/CPHA, SCLK divider and one-hot chip selects.
// Define SPI_LSB_FIRST_EN to add the i_lsb_first port; otherwise transfers are MSB-first.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned CLK_DIV_W = 8,
  localparam int unsigned CS_W     = cs_width(NUM_CS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [DATA_W-1:0]    i_tx_data,
  input  logic [CS_W-1:0]      i_cs_sel,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic [CLK_DIV_W-1:0] i_clk_div,
`ifdef SPI_LSB_FIRST_EN
  input  logic                 i_lsb_first,
`endif
  output logic [DATA_W-1:0]    o_rx_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_sclk,
  output logic                 o_mosi,
  input  logic                 i_miso,
  output logic [NUM_CS-1:0]    o_cs_n
);

  localparam int unsigned EDGE_W = edge_width(DATA_W);

  spi_state_e           r_state, w_state_d;
  spi_mode_t            r_mode;
  logic [CS_W-1:0]      r_cs_sel;
  logic [CLK_DIV_W-1:0] r_clk_div;
  logic [CLK_DIV_W-1:0] r_wait;
  logic [DATA_W-1:0]    r_tx_sh;
  logic [DATA_W-1:0]    r_rx_sh;
  logic [DATA_W-1:0]    r_rx_data;
  logic                 r_mosi;
  logic                 r_sclk;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_phase_end;
  logic                 w_lead, w_trail, w_tick, w_last;
  logic                 w_sample, w_shift;
  logic                 w_lsb_in, w_lsb;
  logic [EDGE_W-1:0]    w_edge_cnt;
  logic [NUM_CS-1:0]    w_cs_n;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsb <= 1'b0;
    end else if (w_accept) begin
      r_lsb <= i_lsb_first;
    end
  end

  assign w_lsb_in = i_lsb_first;
  assign w_lsb    = r_lsb;
`else
  assign w_lsb_in = 1'b0;
  assign w_lsb    = 1'b0;
`endif

  assign w_busy      = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
  assign w_accept    = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_phase_end = (r_wait == r_clk_div);

  spi_sclk_gen #(
    .DATA_W    (DATA_W),
    .CLK_DIV_W (CLK_DIV_W)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (r_state == XFER),
    .i_clk_div   (r_clk_div),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_edge_cnt  (w_edge_cnt)
  );

  assign w_tick = w_lead | w_trail;
  assign w_last = w_tick && (w_edge_cnt == EDGE_W'(2 * DATA_W - 1));

  // CPHA=0 presents bit 0 before the first edge, so the final trailing edge has nothing to shift.
  assign w_sample = r_mode.cpha ? w_trail : w_lead;
  assign w_shift  = r_mode.cpha ? w_lead : (w_trail & ~w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_d = SETUP;
      SETUP:   if (w_phase_end) w_state_d = XFER;
      XFER:    if (w_last) w_state_d = HOLD;
      HOLD:    if (w_phase_end) w_state_d = DONE;
      DONE:    w_state_d = i_start ? SETUP : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (((r_state == SETUP) || (r_state == HOLD)) && !w_phase_end) begin
      r_wait <= r_wait + CLK_DIV_W'(1);
    end else begin
      r_wait <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= '0;
      r_cs_sel  <= '0;
      r_clk_div <= '0;
    end else if (w_accept) begin
      r_mode    <= '{cpol: i_cpol, cpha: i_cpha};
      r_cs_sel  <= i_cs_sel;
      r_clk_div <= i_clk_div;
    end
  end

  // SCLK parks at the latched CPOL; an even number of toggles brings it back there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk <= 1'b0;
    end else if (w_accept) begin
      r_sclk <= i_cpol;
    end else if (w_tick) begin
      r_sclk <= ~r_sclk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh <= '0;
      r_mosi  <= 1'b0;
    end else if (w_accept) begin
      if (i_cpha) begin
        r_tx_sh <= i_tx_data;
      end else begin
        r_mosi  <= first_bit(i_tx_data, w_lsb_in);
        r_tx_sh <= shift_out(i_tx_data, w_lsb_in);
      end
    end else if (w_shift) begin
      r_mosi  <= first_bit(r_tx_sh, w_lsb);
      r_tx_sh <= shift_out(r_tx_sh, w_lsb);
    end
  end

  // LSB-first enters at the top and walks down, so the first bit ends in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sh <= '0;
    end else if (w_accept) begin
      r_rx_sh <= '0;
    end else if (w_sample) begin
      r_rx_sh <= w_lsb ? {i_miso, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], i_miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data <= '0;
    end else if ((r_state == HOLD) && w_phase_end) begin
      r_rx_data <= r_rx_sh;
    end
  end

  // Out-of-range selects match no index and leave every chip select high.
  always_comb begin
    w_cs_n = '1;
    if (w_busy) begin
      for (int i = 0; i < int'(NUM_CS); i++) begin
        if (int'(r_cs_sel) == i) w_cs_n[i] = 1'b0;
      end
    end
  end

  assign o_busy    = w_busy;
  assign o_done    = (r_state == DONE);
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = w_cs_n;
  assign o_rx_data = r_rx_data;

endmodule
